// File: rtl/singleport_ram_arbiter.sv
// ---------------------------------------------------------------------------
// singleport_ram_arbiter
//
// Purpose:
//   Shares one single-port RAM between two requesters (A and B) with a
//   round-robin arbiter. One command (read or write) is accepted per clock
//   and registered onto the RAM port. Reads are tracked through a tag
//   pipeline so that each requester gets its own read-data-valid strobe,
//   returned in grant order.
//
// Parameters:
//   data_width : RAM word width
//   ram_depth  : number of RAM words (address width = clog2(ram_depth))
//   rd_latency : cycles from the registered RAM command to ram_data_out
//                valid (1..4)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   req_a/_b     in   command valid
//   we_a/_b      in   1 = write, 0 = read
//   addr_a/_b    in   command address
//   wdata_a/_b   in   write data
//   gnt_a/_b     out  command accepted this cycle (combinational)
//   rdata_a/_b   out  read data (shared RAM output bus)
//   rvalid_a/_b  out  read data valid strobe for that requester
//   ram_addr     out  RAM address
//   ram_data_in  out  RAM write data
//   ram_we       out  RAM write enable
//   ram_data_out in   RAM read data
//   busy         out  high while any read is in flight
// ---------------------------------------------------------------------------
module singleport_ram_arbiter #(
  parameter  int data_width = 16,
  parameter  int ram_depth  = 1024,
  parameter  int rd_latency = 1,
  localparam int addr_width = $clog2(ram_depth)
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [addr_width-1:0] addr_a,
  input  logic [data_width-1:0] wdata_a,
  output logic                  gnt_a,
  output logic [data_width-1:0] rdata_a,
  output logic                  rvalid_a,

  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [addr_width-1:0] addr_b,
  input  logic [data_width-1:0] wdata_b,
  output logic                  gnt_b,
  output logic [data_width-1:0] rdata_b,
  output logic                  rvalid_b,

  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_data_out,

  output logic                  busy
);

  // Priority pointer: names the side that wins when both request.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } side_t;

  side_t ptr;
  side_t ptr_next;

  // Winner's command, selected by the grant.
  logic                  any_gnt;
  logic                  sel_we;
  logic [addr_width-1:0] sel_addr;
  logic [data_width-1:0] sel_wdata;

  // Read command currently sitting in the RAM command register.
  logic cmd_rd;
  logic cmd_owner;

  // Tag pipeline: one {valid, owner} entry per cycle of RAM read latency.
  // Owner 0 = A, 1 = B.
  logic [rd_latency-1:0] tag_valid;
  logic [rd_latency-1:0] tag_owner;

  // Arbitration. Grants are held low during reset so that no requester
  // believes a transfer happened on a reset edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset) begin
      if (req_a && (!req_b || ptr == PTR_A)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // After any grant, the side that lost (or did not ask) gets priority next.
  always_comb begin
    ptr_next = ptr;
    if (gnt_a) begin
      ptr_next = PTR_B;
    end else if (gnt_b) begin
      ptr_next = PTR_A;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= PTR_A;
    end else begin
      ptr <= ptr_next;
    end
  end

  assign any_gnt   = gnt_a | gnt_b;
  assign sel_we    = gnt_b ? we_b    : we_a;
  assign sel_addr  = gnt_b ? addr_b  : addr_a;
  assign sel_wdata = gnt_b ? wdata_b : wdata_a;

  // RAM command register. Address and data hold when idle; only the
  // write enable and the pending-read flag drop so the RAM sees no
  // spurious command.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      cmd_rd      <= 1'b0;
      cmd_owner   <= 1'b0;
    end else if (any_gnt) begin
      ram_we      <= sel_we;
      ram_addr    <= sel_addr;
      ram_data_in <= sel_wdata;
      cmd_rd      <= ~sel_we;
      cmd_owner   <= gnt_b;
    end else begin
      ram_we      <= 1'b0;
      cmd_rd      <= 1'b0;
    end
  end

  // The tag enters the pipeline on the same edge the RAM samples the
  // command, so it emerges exactly when the RAM data does. Reset drops
  // every in-flight tag so discarded reads never raise rvalid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= cmd_rd;
      tag_owner[0] <= cmd_owner;
      for (int i = 1; i < rd_latency; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign rvalid_a = tag_valid[rd_latency-1] & ~tag_owner[rd_latency-1];
  assign rvalid_b = tag_valid[rd_latency-1] &  tag_owner[rd_latency-1];

  // Both requesters see the RAM output bus; rvalid says whose data it is.
  assign rdata_a = ram_data_out;
  assign rdata_b = ram_data_out;

  assign busy = cmd_rd | (|tag_valid);

endmodule

// File: tb/tb_singleport_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_singleport_ram_arbiter
//
// Purpose:
//   Self-checking bench for singleport_ram_arbiter. Contains a behavioural
//   single-port RAM with registered read, plus a reference model that keeps
//   the memory contents as an array and outstanding read responses as a
//   queue of {owner, data, due cycle}.
// ---------------------------------------------------------------------------
module tb_singleport_ram_arbiter;

  localparam int DW     = 16;
  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int RD_LAT = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_a, we_a, gnt_a, rvalid_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a, rdata_a;
  logic          req_b, we_b, gnt_b, rvalid_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b, rdata_b;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic          ram_we, busy;

  always #5 clock = ~clock;

  singleport_ram_arbiter #(
    .data_width (DW),
    .ram_depth  (DEPTH),
    .rd_latency (RD_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_a        (req_a),
    .we_a         (we_a),
    .addr_a       (addr_a),
    .wdata_a      (wdata_a),
    .gnt_a        (gnt_a),
    .rdata_a      (rdata_a),
    .rvalid_a     (rvalid_a),
    .req_b        (req_b),
    .we_b         (we_b),
    .addr_b       (addr_b),
    .wdata_b      (wdata_b),
    .gnt_b        (gnt_b),
    .rdata_b      (rdata_b),
    .rvalid_b     (rvalid_b),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out),
    .busy         (busy)
  );

  // Behavioural single-port RAM: write on the edge, read registered with
  // RD_LAT cycles of latency.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];

  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data_in;
    rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_data_out = rd_pipe[RD_LAT-1];

  // Snapshot of everything observable in one cycle.
  typedef struct packed {
    logic          gnt_a;
    logic          gnt_b;
    logic          rvalid_a;
    logic          rvalid_b;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
  } view_t;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  // Reference model state.
  resp_t         resp_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic          ptr_m      = 1'b0;
  logic          cmd_we_m   = 1'b0;
  logic [AW-1:0] cmd_addr_m = '0;
  logic [DW-1:0] cmd_data_m = '0;
  int            cyc        = 0;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [5:0] ctrl_of(input view_t v);
    return {v.gnt_a, v.gnt_b, v.rvalid_a, v.rvalid_b, v.busy, v.ram_we};
  endfunction

  // Advance one clock: drive inputs, sample the DUT, and produce what the
  // model predicts for that same cycle, then let the model take the edge.
  task automatic step(input logic rst_n,
                      input logic ra, input logic wa,
                      input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic rb, input logic wb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      output view_t got, output view_t want);
    logic          win_a, win_b, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clock);
    reset = rst_n;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    #1;
    got = '{gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we,
            ram_addr, ram_data_in, rdata_a, rdata_b};

    win_a = rst_n && ra && (!rb || ptr_m == 1'b0);
    win_b = rst_n && rb && !win_a;
    want = '0;
    want.gnt_a       = win_a;
    want.gnt_b       = win_b;
    want.ram_we      = cmd_we_m;
    want.ram_addr    = cmd_addr_m;
    want.ram_data_in = cmd_data_m;
    want.busy        = (resp_q.size() != 0);
    if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
      want.rvalid_a = !resp_q[0].owner;
      want.rvalid_b =  resp_q[0].owner;
      want.rdata_a  = resp_q[0].data;
      want.rdata_b  = resp_q[0].data;
      void'(resp_q.pop_front());
    end

    if (!rst_n) begin
      resp_q.delete();
      ptr_m = 1'b0; cmd_we_m = 1'b0; cmd_addr_m = '0; cmd_data_m = '0;
    end else if (win_a || win_b) begin
      w = win_a ? wa : wb;
      a = win_a ? aa : ab;
      d = win_a ? da : db;
      ptr_m = win_a;
      cmd_we_m = w; cmd_addr_m = a; cmd_data_m = d;
      if (w) mem_m[a] = d;
      else resp_q.push_back('{owner: win_b, data: mem_m[a], due: cyc + 1 + RD_LAT});
    end else begin
      cmd_we_m = 1'b0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    view_t got, want;
    logic  ra, rb;
    $display("[TB] test_reset");
    for (int i = 0; i < 50; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      step(1'b0, ra, 1'b0, AW'(i), '0, rb, 1'b1, AW'(i), '0, got, want);
      vectors++;
      if ({got.gnt_a, got.gnt_b} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL rst_gnt: got %b want 00", {got.gnt_a, got.gnt_b});
      end
      if (i > 0) begin
        vectors++;
        if ({got.ram_we, got.rvalid_a, got.rvalid_b, got.busy} !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL rst_regs: got %b want 0000",
                   {got.ram_we, got.rvalid_a, got.rvalid_b, got.busy});
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
      vectors++;
      if (ctrl_of(got) !== 6'b0 || {got.ram_addr, got.ram_data_in} !== '0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_rst: got ctrl %b addr %h data %h want all zero",
                 ctrl_of(got), got.ram_addr, got.ram_data_in);
      end
    end
  endtask

  task automatic test_fill();
    view_t got, want;
    $display("[TB] test_fill");
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b1, AW'(i), DW'(i * 15), 1'b0, 1'b0, '0, '0, got, want);
      vectors++;
      if (got.gnt_a !== 1'b1 || got.gnt_b !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_gnt[%0d]: got %b%b want 10", i, got.gnt_a, got.gnt_b);
      end
      vectors++;
      if (i == 0) begin
        if (got.ram_we !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL fill_first_we: got %b want 0", got.ram_we);
        end
      end else if ({got.ram_we, got.ram_addr, got.ram_data_in} !== {1'b1, AW'(i - 1), DW'((i - 1) * 15)}) begin
        miscompares++;
        $display("[TB] FAIL fill_cmd[%0d]: got we %b addr %h data %h want 1 %h %h",
                 i, got.ram_we, got.ram_addr, got.ram_data_in, AW'(i - 1), DW'((i - 1) * 15));
      end
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
    vectors++;
    if ({got.ram_we, got.ram_addr} !== {1'b1, 10'd1023}) begin
      miscompares++;
      $display("[TB] FAIL fill_last: got we %b addr %h want 1 3ff", got.ram_we, got.ram_addr);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
    vectors++;
    if ({got.ram_we, got.ram_addr} !== {1'b0, 10'd1023}) begin
      miscompares++;
      $display("[TB] FAIL fill_idle_hold: got we %b addr %h want 0 3ff", got.ram_we, got.ram_addr);
    end
  endtask

  task automatic test_readback();
    view_t got, want;
    int    rv_count = 0;
    $display("[TB] test_readback");
    for (int i = 0; i < DEPTH + RD_LAT + 2; i++) begin
      if (i < DEPTH) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0, got, want);
      else           step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
      vectors++;
      if (ctrl_of(got) !== ctrl_of(want)) begin
        miscompares++;
        $display("[TB] FAIL rb_ctrl[%0d]: got %b want %b", i, ctrl_of(got), ctrl_of(want));
      end
      if (want.rvalid_b) begin
        vectors++;
        if (got.rdata_b !== want.rdata_b) begin
          miscompares++;
          $display("[TB] FAIL rb_data[%0d]: got %h want %h", i, got.rdata_b, want.rdata_b);
        end
      end
      if (got.rvalid_b === 1'b1) rv_count++;
    end
    vectors++;
    if (rv_count !== DEPTH) begin
      miscompares++;
      $display("[TB] FAIL rb_count: got %0d want %0d", rv_count, DEPTH);
    end
  endtask

  task automatic test_contention();
    view_t         got, want;
    logic [DW-1:0] bdata [8];
    int            na = 0, nb = 0, k = 0, ga = 0, gb = 0;
    $display("[TB] test_contention");
    for (int i = 0; i < 8; i++) bdata[i] = DW'($urandom);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
    while ((na < 8 || nb < 8 || resp_q.size() != 0) && k < 40) begin
      step(1'b1, na < 8, 1'b0, AW'(na), '0, nb < 8, 1'b1, AW'(100 + nb), bdata[nb % 8], got, want);
      if (k < 16) begin
        vectors++;
        if ({got.gnt_a, got.gnt_b} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("[TB] FAIL cont_alt[%0d]: got %b%b want %b", k, got.gnt_a, got.gnt_b,
                   (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (got.gnt_a === 1'b1) ga++;
        if (got.gnt_b === 1'b1) gb++;
      end
      vectors++;
      if (ctrl_of(got) !== ctrl_of(want)) begin
        miscompares++;
        $display("[TB] FAIL cont_ctrl[%0d]: got %b want %b", k, ctrl_of(got), ctrl_of(want));
      end
      if (want.rvalid_a) begin
        vectors++;
        if (got.rdata_a !== want.rdata_a) begin
          miscompares++;
          $display("[TB] FAIL cont_rdata[%0d]: got %h want %h", k, got.rdata_a, want.rdata_a);
        end
      end
      if (want.gnt_a) na++;
      if (want.gnt_b) nb++;
      k++;
    end
    vectors++;
    if (ga !== 8 || gb !== 8) begin
      miscompares++;
      $display("[TB] FAIL cont_count: got A %0d B %0d want 8 8 within 16 cycles", ga, gb);
    end
  endtask

  task automatic test_raw();
    view_t got, want;
    int    seen = 0;
    $display("[TB] test_raw");
    for (int i = 0; i < RD_LAT + 4; i++) begin
      if (i == 0)      step(1'b1, 1'b1, 1'b1, 10'd5, 16'h1234, 1'b0, 1'b0, '0, '0, got, want);
      else if (i == 1) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0, got, want);
      else             step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
      vectors++;
      if (ctrl_of(got) !== ctrl_of(want)) begin
        miscompares++;
        $display("[TB] FAIL raw_ctrl[%0d]: got %b want %b", i, ctrl_of(got), ctrl_of(want));
      end
      if (got.rvalid_b === 1'b1) begin
        seen++;
        vectors++;
        if (got.rdata_b !== 16'h1234) begin
          miscompares++;
          $display("[TB] FAIL raw_data: got %h want 1234", got.rdata_b);
        end
      end
    end
    vectors++;
    if (seen !== 1) begin
      miscompares++;
      $display("[TB] FAIL raw_rvalid_count: got %0d want 1", seen);
    end
  endtask

  task automatic test_reset_midflight();
    view_t got, want;
    $display("[TB] test_reset_midflight");
    step(1'b1, 1'b1, 1'b0, 10'd3, '0, 1'b0, 1'b0, '0, '0, got, want);
    vectors++;
    if (got.gnt_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mf_gnt: got %b want 1", got.gnt_a);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
    vectors++;
    if (got.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mf_busy_pre: got %b want 1", got.busy);
    end
    for (int i = 0; i < RD_LAT + 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, got, want);
      vectors++;
      if ({got.rvalid_a, got.rvalid_b, got.busy, got.ram_we} !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL mf_after[%0d]: got rvA/rvB/busy/we %b want 0000", i,
                 {got.rvalid_a, got.rvalid_b, got.busy, got.ram_we});
      end
    end
    step(1'b1, 1'b1, 1'b1, 10'd200, 16'hA5A5, 1'b1, 1'b1, 10'd201, 16'h5A5A, got, want);
    vectors++;
    if ({got.gnt_a, got.gnt_b} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mf_ptr: got %b%b want 10", got.gnt_a, got.gnt_b);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd201, 16'h5A5A, got, want);
    vectors++;
    if ({got.gnt_a, got.gnt_b} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mf_second: got %b%b want 01", got.gnt_a, got.gnt_b);
    end
  endtask

  task automatic test_random();
    view_t         got, want;
    logic          pa = 1'b0, pb = 1'b0, wa = 1'b0, wb = 1'b0, rst_n;
    logic [AW-1:0] aa = '0, ab = '0;
    logic [DW-1:0] da = '0, db = '0;
    $display("[TB] test_random");
    for (int i = 0; i < 2000 + RD_LAT + 2; i++) begin
      if (i < 2000) begin
        if (!pa && $urandom_range(0, 3) != 0) begin
          pa = 1'b1; wa = 1'($urandom_range(0, 1));
          aa = AW'($urandom_range(0, DEPTH - 1)); da = DW'($urandom);
        end
        if (!pb && $urandom_range(0, 3) != 0) begin
          pb = 1'b1; wb = 1'($urandom_range(0, 1));
          ab = AW'($urandom_range(0, DEPTH - 1)); db = DW'($urandom);
        end
        rst_n = ($urandom_range(0, 149) != 0);
      end else begin
        pa = 1'b0; pb = 1'b0; rst_n = 1'b1;
      end
      step(rst_n, pa, wa, aa, da, pb, wb, ab, db, got, want);
      vectors++;
      if (ctrl_of(got) !== ctrl_of(want)) begin
        miscompares++;
        $display("[TB] FAIL rnd_ctrl[%0d]: got %b want %b", i, ctrl_of(got), ctrl_of(want));
      end
      vectors++;
      if ({got.ram_addr, got.ram_data_in} !== {want.ram_addr, want.ram_data_in}) begin
        miscompares++;
        $display("[TB] FAIL rnd_cmd[%0d]: got addr %h data %h want %h %h", i,
                 got.ram_addr, got.ram_data_in, want.ram_addr, want.ram_data_in);
      end
      if (want.rvalid_a) begin
        vectors++;
        if (got.rdata_a !== want.rdata_a) begin
          miscompares++;
          $display("[TB] FAIL rnd_rdata_a[%0d]: got %h want %h", i, got.rdata_a, want.rdata_a);
        end
      end
      if (want.rvalid_b) begin
        vectors++;
        if (got.rdata_b !== want.rdata_b) begin
          miscompares++;
          $display("[TB] FAIL rnd_rdata_b[%0d]: got %h want %h", i, got.rdata_b, want.rdata_b);
        end
      end
      // Granted commands retire; ungranted ones are occasionally abandoned.
      if (want.gnt_a || (pa && $urandom_range(0, 9) == 0)) pa = 1'b0;
      if (want.gnt_b || (pb && $urandom_range(0, 9) == 0)) pb = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    test_reset();
    test_fill();
    test_readback();
    test_contention();
    test_raw();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/singleport_ram_arbiter.md
Name: singleport_ram_arbiter

Overview:
Two-requester round-robin arbiter that shares one singleport_ram instance (data_width 16, ram_depth 1024) between ports A and B.
- Accepts one read or write per clock cycle and registers the winning command onto the RAM port.
- Tracks in-flight reads with a tag pipeline so each requester receives its own read-data-valid strobe.
- Sits between two DMA/processing engines and the RAM.

Parameters:
data_width, 16, RAM word width
ram_depth, 1024, RAM words; address width = clog2(ram_depth) = 10
rd_latency, 1, clock cycles from RAM command (ram_addr/ram_we registered) to ram_data_out valid; legal range 1..4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req_a  in  1  requester A command valid
we_a  in  1  A: 1 = write, 0 = read
addr_a  in  10  A address
wdata_a  in  16  A write data
gnt_a  out  1  A command accepted this cycle (combinational)
rdata_a  out  16  A read data
rvalid_a  out  1  rdata_a valid strobe
req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b, rvalid_b  same as A for requester B
ram_addr  out  10  to RAM addra
ram_data_in  out  16  to RAM data_ina
ram_we  out  1  to RAM we_a
ram_data_out  in  16  from RAM data_outa
busy  out  1  high while any read is in flight

Behaviour:
- Reset is sampled only on the clock edge while reset == 0.
- Register values after reset:
  - ram_we = 0, ram_addr = 0, ram_data_in = 0.
  - Priority pointer = A.
  - Tag pipeline cleared; rvalid_a = rvalid_b = 0; busy = 0.
  - gnt_a/gnt_b forced to 0 while reset == 0.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high in the same cycle.
  - The transfer occurs on the edge where req & gnt = 1.
  - A requester may drop req before being granted (abandon); this is legal.
- Arbitration (combinational, every cycle):
  - Only one requester active: grant it.
  - Both active: grant the side named by the priority pointer.
  - Pointer update: on any grant, pointer <= the non-granted side. With no grant, pointer holds.
  - Result: under continuous contention, grants alternate A, B, A, B.
  - gnt_a and gnt_b are never both 1.
- Command stage (registered):
  - On a grant at edge T, ram_addr/ram_data_in/ram_we take the winner's addr/wdata/we at T.
  - With no grant, ram_we <= 0; addr and data hold.
- Tag pipeline:
  - Depth rd_latency; entry = {valid, owner}.
  - Entry pushed at edge T: valid = grant & ~we, owner = 0 for A / 1 for B.
  - Pipeline output drives rvalid_a = valid & owner == 0, rvalid_b = valid & owner == 1.
  - Read-grant latency: rvalid is high in cycle T+1+rd_latency (cycle T+2 for the default). It lasts exactly 1 cycle.
- Read data: rdata_a = rdata_b = ram_data_out (shared bus). Data is qualified only by the corresponding rvalid.
- busy = OR of all tag valid bits, plus the pending-read command register.
- Writes produce no rvalid. Back-to-back reads sustain 1 per cycle with no bubbles.
- Ordering:
  - Read-after-write to the same address from either side returns the new data, because the RAM write precedes the later read command.
  - Responses return in grant order.
- Address wrap: the 10-bit addr is passed unmodified; 1023 + 1 wrapping is the requester's concern.
- Reset mid-operation: in-flight tags are discarded, so no rvalid is issued for them. ram_we is 0 from the reset edge onward. A pending req must be re-presented after reset releases.

Test Plan:
- Reset released after 500 ns, no requests -> ram_we = 0, gnt_a = gnt_b = 0, rvalid_a/b = 0, busy = 0 for 20 cycles.
- Fill: A writes addr 0..1023 with data = addr*15 (16-bit), req held continuously -> gnt_a every cycle, ram_we = 1 for 1024 consecutive cycles, ram_addr trailing addr_a by 1 cycle.
- Readback: B reads 0..1023 back-to-back -> rvalid_b high 1024 consecutive cycles starting 2 cycles after first gnt_b, rdata_b = addr*15, rvalid_a never high.
- Contention: A and B both request continuously (A reads 0..7, B writes 100..107) -> grants alternate A, B starting with A after reset. Each side completes 8 transfers within 16 cycles. A's rdata matches the earlier fill values.
- Read-after-write: A writes 0x1234 to addr 5, B reads addr 5 on the next cycle -> rvalid_b with rdata_b = 0x1234.
- Reset mid-flight: A issues a read to addr 3, reset asserted on the next edge -> no rvalid_a, busy = 0 and ram_we = 0 after that edge. Pointer is back to A.
